// File: rtl/jtag_dbg_target.sv
// Debug target downstream of jtag_top: services the DM memory bus with an
// on-chip word RAM, a halt-gated GPR file, a halt status flag and a
// retriggerable stretched core-reset pulse.
module jtag_dbg_target #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int RST_PULSE   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        busy_o,
    output logic        err_o,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    input  logic        halt_req_i,
    input  logic        reset_req_i,
    output logic        halted_o,
    output logic        core_rst_o
);
    localparam int          LP_AW       = $clog2(MEM_WORDS);
    localparam logic [15:0] LP_CNT_LAST = 16'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [15:0] LP_PULSE    = 16'(RST_PULSE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req_q;
    logic               w_launch;
    logic               r_we;
    logic [31:2]        r_addr;
    logic [31:0]        r_wdata;
    logic [15:0]        r_cnt;
    logic [LP_AW-1:0]   w_idx;
    logic               w_oor;
    logic [31:0]        r_mem [MEM_WORDS];
    logic               r_busy;
    logic               r_err;
    logic [31:0]        r_mem_rdata;
    logic [31:0]        r_gpr [32];
    logic [31:0]        r_reg_rdata;
    logic               r_halted;
    logic               r_rreq_q;
    logic [15:0]        r_rcnt;
    logic [15:0]        w_rcnt_nxt;
    logic               w_rst_edge;
    logic               w_gpr_clr;
    logic               r_core_rst;
    logic               w_unused_addr_lsb;

    // Byte-lane bits of the address carry no meaning for word accesses.
    assign w_unused_addr_lsb = ^mem_addr_i[1:0];

    // A launch needs a fresh rising edge of the request while the FSM is idle.
    assign w_launch = op_req_i & ~r_req_q & (r_state == ST_IDLE);
    assign w_idx    = r_addr[LP_AW+1:2];
    assign w_oor    = |r_addr[31:LP_AW+2];

    // Memory FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory FSM next-state logic; DONE parks until the request drops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (!op_req_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, wait counter, status flags and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 30'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= 16'd0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_req_q <= op_req_i;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_we    <= mem_we_i;
                        r_addr  <= mem_addr_i[31:2];
                        r_wdata <= mem_wdata_i;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                ST_WAIT: r_cnt <= r_cnt + 16'd1;
                ST_ACCESS: begin
                    if (w_oor) begin
                        r_err <= 1'b1;
                    end else if (!r_we) begin
                        r_mem_rdata <= r_mem[w_idx];
                    end
                end
                ST_DONE: r_busy <= 1'b0;
                default: r_busy <= 1'b0;
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((r_state == ST_ACCESS) && r_we && !w_oor) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Core-reset counter: rising request edge (re)loads, otherwise count down.
    assign w_rst_edge = reset_req_i & ~r_rreq_q;
    always_comb begin
        w_rcnt_nxt = r_rcnt;
        w_gpr_clr  = 1'b0;
        if (w_rst_edge) begin
            w_rcnt_nxt = LP_PULSE;
        end else if (r_rcnt != 16'd0) begin
            w_rcnt_nxt = r_rcnt - 16'd1;
            w_gpr_clr  = (r_rcnt == 16'd1);
        end else begin
            w_rcnt_nxt = r_rcnt;
        end
    end

    // Core-reset pulse register and request edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rreq_q   <= 1'b0;
            r_rcnt     <= 16'd0;
            r_core_rst <= 1'b0;
        end else begin
            r_rreq_q   <= reset_req_i;
            r_rcnt     <= w_rcnt_nxt;
            r_core_rst <= (w_rcnt_nxt != 16'd0);
        end
    end

    // Halt flag and GPR file; end of a core reset wipes the GPRs, x0 stays 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted    <= 1'b0;
            r_reg_rdata <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'd0;
            end
        end else begin
            r_halted    <= halt_req_i;
            r_reg_rdata <= r_gpr[reg_addr_i];
            if (w_gpr_clr) begin
                for (int i = 0; i < 32; i++) begin
                    r_gpr[i] <= 32'd0;
                end
            end else if (r_halted && reg_we_i && (reg_addr_i != 5'd0)) begin
                r_gpr[reg_addr_i] <= reg_wdata_i;
            end
        end
    end

    assign mem_rdata_o = r_mem_rdata;
    assign busy_o      = r_busy;
    assign err_o       = r_err;
    assign reg_rdata_o = r_reg_rdata;
    assign halted_o    = r_halted;
    assign core_rst_o  = r_core_rst;

endmodule

// File: tb/tb_jtag_dbg_target.sv
// Self-checking bench for jtag_dbg_target: directed scenarios plus randomized
// memory and GPR traffic, compared against a transaction-level model.
module tb_jtag_dbg_target;
    localparam int MEM_WORDS   = 1024;
    localparam int WAIT_CYCLES = 2;
    localparam int RST_PULSE   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, err;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        halt_req, reset_req, halted, core_rst;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_mem [MEM_WORDS];
    bit          m_valid [16];
    logic [31:0] m_rdata;
    logic [31:0] m_gpr [32];
    logic        m_halted;
    logic        m_rreq_q;
    int          m_rcnt;
    logic [31:0] exp_reg_rdata;

    jtag_dbg_target #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES), .RST_PULSE(RST_PULSE)) dut (
        .clk(clk), .rst(rst),
        .op_req_i(op_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .busy_o(busy), .err_o(err),
        .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata),
        .halt_req_i(halt_req), .reset_req_i(reset_req), .halted_o(halted), .core_rst_o(core_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear_gpr();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    endtask

    // Advance one clock: update the model from the inputs present before the edge,
    // then compare the always-observable side outputs.
    task automatic tick();
        if (rst) begin
            model_clear_gpr();
            m_halted = 1'b0; m_rcnt = 0; m_rreq_q = 1'b0; exp_reg_rdata = 32'd0;
        end else begin
            exp_reg_rdata = m_gpr[reg_addr];
            if (m_halted && reg_we && reg_addr != 5'd0) m_gpr[reg_addr] = reg_wdata;
            if (reset_req && !m_rreq_q) begin
                m_rcnt = RST_PULSE;
            end else if (m_rcnt > 0) begin
                m_rcnt--;
                if (m_rcnt == 0) model_clear_gpr();
            end
            m_halted = halt_req;
            m_rreq_q = reset_req;
        end
        @(posedge clk); #1;
        check("reg_rdata", reg_rdata, exp_reg_rdata);
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("core_rst", {31'd0, core_rst}, {31'd0, (m_rcnt != 0)});
    endtask

    // One DM memory access; inputs are scrambled after launch to prove they are captured.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int  n;
        bit  oor;
        int  idx;
        oor = (addr >= 32'(MEM_WORDS * 4));
        idx = int'(addr[11:2]);
        op_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        tick();
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("err_clr", {31'd0, err}, 32'd0);
        mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("busy_len", n, WAIT_CYCLES + 2);
        if (!oor) begin
            if (we) begin
                m_mem[idx] = wd;
                if (idx < 16) m_valid[idx] = 1'b1;
            end else begin
                m_rdata = m_mem[idx];
            end
        end
        check("mem_rdata", mem_rdata, m_rdata);
        check("err", {31'd0, err}, {31'd0, oor});
        if (!hold) begin
            op_req = 1'b0;
            tick();
        end
    endtask

    initial begin
        int nbusy;
        int nhigh;
        int sel;
        int idx;
        logic [31:0] a;
        rst = 1'b1; op_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        reg_we = 1'b0; reg_addr = 5'd0; reg_wdata = 32'd0; halt_req = 1'b0; reset_req = 1'b0;
        model_clear_gpr();
        m_halted = 1'b0; m_rreq_q = 1'b0; m_rcnt = 0; m_rdata = 32'd0; exp_reg_rdata = 32'd0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Basic write then read
        do_access(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
        do_access(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t1_rdata", mem_rdata, 32'h1234_5678);

        // Out-of-range read keeps rdata, sets err; next in-range launch clears err
        do_access(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        check("t2_hold", mem_rdata, 32'h1234_5678);
        check("t2_err", {31'd0, err}, 32'd1);
        do_access(1'b0, 32'h0000_0013, 32'h0, 1'b0);

        // Request held high: exactly one access, no relaunch
        do_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            mem_we = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = $urandom;
            tick();
            if (busy !== 1'b0) nbusy++;
        end
        check("t3_no_relaunch", nbusy, 0);
        op_req = 1'b0;
        tick();
        do_access(1'b0, 32'h0000_0020, 32'h0, 1'b0);
        check("t3_single_write", mem_rdata, 32'hCAFE_F00D);

        // GPR writes only while halted, x0 hardwired
        halt_req = 1'b0; tick();
        reg_we = 1'b1; reg_addr = 5'd5; reg_wdata = 32'h0000_A5A5; tick();
        reg_we = 1'b0; tick();
        check("t4_drop", reg_rdata, 32'd0);
        halt_req = 1'b1; tick();
        reg_we = 1'b1; tick();
        reg_we = 1'b0; tick();
        check("t4_x5", reg_rdata, 32'h0000_A5A5);
        reg_we = 1'b1; reg_addr = 5'd0; reg_wdata = 32'd1; tick();
        reg_we = 1'b0; tick();
        check("t4_x0", reg_rdata, 32'd0);

        // Random GPR / halt / core-reset traffic
        for (int i = 0; i < 120; i++) begin
            halt_req  = ($urandom_range(0, 3) != 0);
            reg_we    = 1'($urandom);
            reg_addr  = 5'($urandom);
            reg_wdata = $urandom;
            reset_req = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset_req = 1'b0; reg_we = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Retriggered core reset: 5 + 16 cycles, GPRs wiped, RAM intact
        halt_req = 1'b1; reg_we = 1'b1; reg_addr = 5'd7; reg_wdata = 32'h7777_0007; tick();
        reg_we = 1'b0;
        reset_req = 1'b1; tick();
        reset_req = 1'b0;
        nhigh = (core_rst === 1'b1) ? 1 : 0;
        for (int i = 1; i < 60; i++) begin
            reset_req = (i == 5);
            tick();
            if (core_rst === 1'b1) nhigh++;
        end
        reset_req = 1'b0;
        check("t5_pulse_len", nhigh, 21);
        tick();
        check("t5_gpr_clr", reg_rdata, 32'd0);
        do_access(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("t5_ram_intact", mem_rdata, 32'h1234_5678);

        // Random memory traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            idx = $urandom_range(0, 15);
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if (sel == 0) begin
                do_access(1'($urandom), $urandom | (32'd1 << $urandom_range(12, 31)), $urandom, 1'b0);
            end else if (sel == 3 && m_valid[idx]) begin
                do_access(1'b0, a, 32'h0, 1'b0);
            end else begin
                do_access(1'b1, a, $urandom, 1'b0);
            end
        end

        // Async reset during WAIT, request held through release relaunches once
        halt_req = 1'b1; reset_req = 1'b1; tick(); reset_req = 1'b0; tick();
        op_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = 32'h0BAD_BEEF;
        tick(); tick();
        rst = 1'b1; #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_err", {31'd0, err}, 32'd0);
        check("t6_halted", {31'd0, halted}, 32'd0);
        check("t6_core_rst", {31'd0, core_rst}, 32'd0);
        check("t6_rdata", mem_rdata, 32'd0);
        m_rdata = 32'd0;
        tick();
        rst = 1'b0;
        do_access(1'b1, 32'h0000_0040, 32'h0BAD_BEEF, 1'b0);
        do_access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
        check("t6_relaunch", mem_rdata, 32'h0BAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
